// File: rtl/mips8_mem_responder.sv
// Memory-side responder for the 8-bit MIPS core: owns the storage array and
// completes each read/write after WAIT_STATES extra cycles with a one-cycle ready pulse.
module mips8_mem_responder #(
    parameter int WIDTH       = 8,
    parameter int AWIDTH      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [AWIDTH-1:0] adr,
    input  logic [WIDTH-1:0]  writedata,
    output logic [WIDTH-1:0]  memdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS
    } state_t;

    localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_next;
    logic [AWIDTH-1:0]  r_adr;
    logic [WIDTH-1:0]   r_wdata;
    logic               r_is_write;
    logic [WIDTH-1:0]   r_memdata;
    logic               r_ready;
    logic               r_err;
    logic               w_req;
    logic               w_conflict;
    logic               w_idle;
    logic               w_commit;

    logic [WIDTH-1:0]   r_mem [0:(1<<AWIDTH)-1];

    always_comb begin
        w_req      = memread ^ memwrite;
        w_conflict = memread & memwrite;
        w_idle     = (r_state == ST_IDLE);
        w_commit   = (r_state == ST_ACCESS);
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_cnt_next = LP_WAIT;
                    w_next     = (LP_WAIT != 4'd0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next     = ST_IDLE;
                w_cnt_next = 4'd0;
            end
        endcase
    end

    // Request capture happens only in IDLE, so input changes mid-transaction are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_adr      <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_memdata  <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_ready <= w_commit;
            r_err   <= w_idle & w_conflict;
            if (w_idle && w_req) begin
                r_adr      <= adr;
                r_wdata    <= writedata;
                r_is_write <= memwrite;
            end
            if (w_commit && !r_is_write) begin
                r_memdata <= r_mem[r_adr];
            end
        end
    end

    // Storage is not cleared by reset, but a reset on the ACCESS edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && w_commit && r_is_write) begin
            r_mem[r_adr] <= r_wdata;
        end
    end

    assign memdata = r_memdata;
    assign ready   = r_ready;
    assign err     = r_err;
    assign busy    = !w_idle;

endmodule

// File: tb/tb_mips8_mem_responder.sv
// Scoreboard bench for mips8_mem_responder: one instance with two wait states,
// one with zero, driven by directed vectors and checked by a negedge monitor.
module tb_mips8_mem_responder;

    typedef struct {
        int         readyEdge;
        logic [7:0] data;
    } sbEntry_t;

    logic       clk = 1'b0;
    logic       rst [2];
    logic       rd  [2];
    logic       wr  [2];
    logic [7:0] ad  [2];
    logic [7:0] wd  [2];
    logic [7:0] md  [2];
    logic       rdy [2];
    logic       bsy [2];
    logic       er  [2];

    int wsOf [2] = '{2, 0};
    int expErrEdge [2] = '{-10, -10};
    bit ignoreBusy [2] = '{1'b0, 1'b0};
    bit monitorOn = 1'b0;
    int edgeCount = 0;
    int nChecks = 0;
    int nFail = 0;

    sbEntry_t sbQ0 [$];
    sbEntry_t sbQ1 [$];

    mips8_mem_responder #(.WIDTH(8), .AWIDTH(8), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(rst[0]), .memread(rd[0]), .memwrite(wr[0]),
        .adr(ad[0]), .writedata(wd[0]), .memdata(md[0]),
        .ready(rdy[0]), .busy(bsy[0]), .err(er[0])
    );

    mips8_mem_responder #(.WIDTH(8), .AWIDTH(8), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst[1]), .memread(rd[1]), .memwrite(wr[1]),
        .adr(ad[1]), .writedata(wd[1]), .memdata(md[1]),
        .ready(rdy[1]), .busy(bsy[1]), .err(er[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) checkOutput(d);
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string name, input logic [7:0] got, input logic [7:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on ready, flags missing/extra pulses, checks busy and err.
    task automatic checkOutput(input int d);
        sbEntry_t e;
        bit have;
        bit expBusy;
        bit expErr;
        if (!monitorOn) return;
        have = (d == 0) ? (sbQ0.size() > 0) : (sbQ1.size() > 0);
        if (have) e = (d == 0) ? sbQ0[0] : sbQ1[0];
        if (rdy[d] === 1'b1) begin
            nChecks++;
            if (!have) begin
                nFail++;
                $display("[TB] FAIL dut%0d unexpected_ready: got ready=1 at edge %0d, expected 0", d, edgeCount);
            end else begin
                if (edgeCount != e.readyEdge || md[d] !== e.data) begin
                    nFail++;
                    $display("[TB] FAIL dut%0d ready_response: got edge %0d data %h, expected edge %0d data %h",
                             d, edgeCount, md[d], e.readyEdge, e.data);
                end
                if (d == 0) void'(sbQ0.pop_front()); else void'(sbQ1.pop_front());
            end
        end else if (have && edgeCount > e.readyEdge) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL dut%0d missed_ready: got no ready by edge %0d, expected at edge %0d",
                     d, edgeCount, e.readyEdge);
            if (d == 0) void'(sbQ0.pop_front()); else void'(sbQ1.pop_front());
        end
        expErr = (edgeCount == expErrEdge[d]);
        nChecks++;
        if (er[d] !== expErr) begin
            nFail++;
            $display("[TB] FAIL dut%0d err: got %b at edge %0d, expected %b", d, er[d], edgeCount, expErr);
        end
        if (!ignoreBusy[d]) begin
            expBusy = have && (edgeCount >= e.readyEdge - 1 - wsOf[d]) && (edgeCount < e.readyEdge);
            nChecks++;
            if (bsy[d] !== expBusy) begin
                nFail++;
                $display("[TB] FAIL dut%0d busy: got %b at edge %0d, expected %b", d, bsy[d], edgeCount, expBusy);
            end
        end
    endtask

    task automatic pushExpect(input int d, input logic [7:0] expMd);
        sbEntry_t e;
        e.readyEdge = edgeCount + 2 + wsOf[d];
        e.data      = expMd;
        if (d == 0) sbQ0.push_back(e); else sbQ1.push_back(e);
    endtask

    task automatic idleInputs(input int d);
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        ad[d] = 8'h00;
        wd[d] = 8'h00;
    endtask

    task automatic waitDone(input int d);
        int n;
        n = 0;
        while (((d == 0) ? sbQ0.size() : sbQ1.size()) != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL dut%0d drain_timeout: got pending entries, expected empty scoreboard", d);
        end
        repeat (2) @(negedge clk);
    endtask

    // One-cycle request; expMd is the memdata value required in the ready cycle.
    task automatic applyStimulus(input int d, input bit isWrite, input logic [7:0] a,
                                 input logic [7:0] w, input logic [7:0] expMd);
        @(negedge clk);
        rd[d] = !isWrite;
        wr[d] = isWrite;
        ad[d] = a;
        wd[d] = w;
        pushExpect(d, expMd);
        @(negedge clk);
        idleInputs(d);
        waitDone(d);
    endtask

    task automatic checkResetOutputs(input int d);
        checkValue($sformatf("dut%0d reset_memdata", d), md[d], 8'h00);
        checkValue($sformatf("dut%0d reset_ready", d), {7'd0, rdy[d]}, 8'h00);
        checkValue($sformatf("dut%0d reset_busy", d), {7'd0, bsy[d]}, 8'h00);
        checkValue($sformatf("dut%0d reset_err", d), {7'd0, er[d]}, 8'h00);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            idleInputs(d);
        end
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        checkResetOutputs(0);
        checkResetOutputs(1);
        monitorOn = 1'b1;

        // Two wait states: write then read back.
        applyStimulus(0, 1'b1, 8'h10, 8'hA5, 8'h00);
        applyStimulus(0, 1'b0, 8'h10, 8'h00, 8'hA5);
        repeat (3) @(negedge clk);
        checkValue("dut0 memdata_hold", md[0], 8'hA5);

        // Zero wait states.
        applyStimulus(1, 1'b1, 8'hFF, 8'h3C, 8'h00);
        applyStimulus(1, 1'b0, 8'hFF, 8'h00, 8'h3C);

        // Simultaneous read and write: err only, array untouched.
        @(negedge clk);
        rd[0] = 1'b1;
        wr[0] = 1'b1;
        ad[0] = 8'h10;
        wd[0] = 8'h11;
        expErrEdge[0] = edgeCount + 1;
        @(negedge clk);
        idleInputs(0);
        repeat (4) @(negedge clk);
        applyStimulus(0, 1'b0, 8'h10, 8'h00, 8'hA5);

        // Inputs changing during WAIT must not disturb the read in flight.
        applyStimulus(0, 1'b1, 8'h20, 8'h5A, 8'hA5);
        @(negedge clk);
        rd[0] = 1'b1;
        ad[0] = 8'h10;
        pushExpect(0, 8'hA5);
        @(negedge clk);
        rd[0] = 1'b0;
        wr[0] = 1'b1;
        ad[0] = 8'h20;
        wd[0] = 8'h00;
        repeat (3) @(negedge clk);
        idleInputs(0);
        waitDone(0);
        applyStimulus(0, 1'b0, 8'h20, 8'h00, 8'h5A);

        // Reset during WAIT aborts the write.
        ignoreBusy[0] = 1'b1;
        @(negedge clk);
        wr[0] = 1'b1;
        ad[0] = 8'h10;
        wd[0] = 8'h77;
        @(negedge clk);
        idleInputs(0);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        checkResetOutputs(0);
        repeat (6) @(negedge clk);
        ignoreBusy[0] = 1'b0;
        applyStimulus(0, 1'b0, 8'h10, 8'h00, 8'hA5);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
